// File: rtl/cpu_pkg.sv
// Shared definitions for the RISC control path: opcodes, FSM states, ALU codes
// and the control vector that the decoder hands back to the sequencer.
package cpu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SLL  = 4'h5;
  localparam logic [3:0] OP_SRL  = 4'h6;
  localparam logic [3:0] OP_ADDI = 4'h7;
  localparam logic [3:0] OP_LW   = 4'h8;
  localparam logic [3:0] OP_SW   = 4'h9;
  localparam logic [3:0] OP_BEQ  = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_OR  = 4'h3;
  localparam logic [3:0] ALU_XOR = 4'h4;
  localparam logic [3:0] ALU_SLL = 4'h5;
  localparam logic [3:0] ALU_SRL = 4'h6;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       sel1;
    logic [1:0] sel2;
    logic       sel3;
    logic       sel5;
    logic       sel6;
    logic       re;
    logic       wr;
    logic       reg_wrt;
    logic       pc_sel;
    logic       im_select;
    logic       branch;
    logic       halted;
  } ctrl_t;

  function automatic logic is_rtype(input logic [3:0] op);
    return op <= OP_SRL;
  endfunction

  function automatic logic is_itype(input logic [3:0] op);
    return (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
  endfunction

  function automatic logic is_nop(input logic [3:0] op);
    return (op >= 4'hC) && (op <= 4'hE);
  endfunction

  // R-type ops carry their own ALU code; address/immediate maths adds, BEQ compares by subtracting.
  function automatic logic [3:0] alu_sel(input logic [3:0] op);
    if (is_rtype(op)) return op;
    if (op == OP_BEQ) return ALU_SUB;
    return ALU_ADD;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational control-vector decode from the sequencer state and the
// instruction opcode; no state of its own.
module ctrl_decode
  import cpu_pkg::*;
#(
  parameter logic [3:0] HALT_OP = 4'hF
) (
  input  state_e     state,
  input  logic [3:0] op,
  input  logic       mem_last,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.im_select = 1'b1;
      end
      S_DECODE: begin
        ctrl.pc_sel = (op != HALT_OP) && is_nop(op);
      end
      S_EXEC: begin
        ctrl.alu_op = alu_sel(op);
        if (is_rtype(op)) begin
          ctrl.sel1 = 1'b1;
        end else if (is_itype(op)) begin
          ctrl.sel2 = 2'd1;
        end else if (op == OP_BEQ) begin
          ctrl.branch = 1'b1;
          ctrl.pc_sel = 1'b1;
        end else if (op == OP_JMP) begin
          ctrl.sel6   = 1'b1;
          ctrl.pc_sel = 1'b1;
        end
      end
      S_MEM: begin
        // Address operands stay selected so the RAM address is stable for the whole access.
        ctrl.alu_op = alu_sel(op);
        ctrl.sel2   = 2'd1;
        ctrl.re     = (op == OP_LW);
        ctrl.wr     = (op == OP_SW);
        ctrl.pc_sel = (op == OP_SW) && mem_last;
      end
      S_WB: begin
        ctrl.alu_op  = alu_sel(op);
        ctrl.sel2    = is_itype(op) ? 2'd1 : 2'd0;
        ctrl.sel1    = is_rtype(op) || (op == OP_ADDI);
        ctrl.sel3    = (op == OP_LW);
        ctrl.reg_wrt = 1'b1;
        ctrl.pc_sel  = 1'b1;
      end
      S_HALT: begin
        ctrl.halted = 1'b1;
      end
      default: begin
        ctrl = '0;
      end
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 16-bit RISC datapath;
// holds state, latched opcode, MEM wait counter and carry flag.
module control_unit
  import cpu_pkg::*;
#(
  parameter int         MEM_WAIT = 1,
  parameter logic [3:0] HALT_OP  = 4'hF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       carry,
  input  logic       run,
  output logic [3:0] alu_op,
  output logic       sel1,
  output logic [1:0] sel2,
  output logic       sel3,
  output logic       sel5,
  output logic       sel6,
  output logic       re,
  output logic       wr,
  output logic       reg_wrt,
  output logic       pc_sel,
  output logic       im_select,
  output logic       branch,
  output logic       carry_flag,
  output logic       halted
);

  state_e     state_q, state_d;
  logic [3:0] op_q, op_d;
  logic [3:0] cnt_q, cnt_d;
  logic       carry_flag_q, carry_flag_d;
  logic [3:0] op_eff;
  ctrl_t      ctrl;

  // op_q only becomes valid at the end of DECODE, so DECODE itself looks at the live opcode.
  assign op_eff = (state_q == S_DECODE) ? opcode : op_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_FETCH;
      op_q         <= 4'h0;
      cnt_q        <= 4'h0;
      carry_flag_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      cnt_q        <= cnt_d;
      carry_flag_q <= carry_flag_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    cnt_d        = cnt_q;
    carry_flag_d = carry_flag_q;
    case (state_q)
      S_FETCH: begin
        state_d = S_DECODE;
      end
      S_DECODE: begin
        op_d = opcode;
        if (opcode == HALT_OP)   state_d = S_HALT;
        else if (is_nop(opcode)) state_d = S_FETCH;
        else                     state_d = S_EXEC;
      end
      S_EXEC: begin
        if (is_rtype(op_q) || (op_q == OP_ADDI)) begin
          carry_flag_d = carry;
          state_d      = S_WB;
        end else if ((op_q == OP_LW) || (op_q == OP_SW)) begin
          cnt_d   = 4'(MEM_WAIT);
          state_d = S_MEM;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        if (cnt_q == 4'd0) begin
          state_d = (op_q == OP_LW) ? S_WB : S_FETCH;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_WB: begin
        state_d = S_FETCH;
      end
      S_HALT: begin
        if (run) state_d = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  ctrl_decode #(
    .HALT_OP (HALT_OP)
  ) u_decode (
    .state    (state_q),
    .op       (op_eff),
    .mem_last (cnt_q == 4'd0),
    .ctrl     (ctrl)
  );

  assign alu_op     = ctrl.alu_op;
  assign sel1       = ctrl.sel1;
  assign sel2       = ctrl.sel2;
  assign sel3       = ctrl.sel3;
  assign sel5       = ctrl.sel5;
  assign sel6       = ctrl.sel6;
  assign re         = ctrl.re;
  assign wr         = ctrl.wr;
  assign reg_wrt    = ctrl.reg_wrt;
  assign pc_sel     = ctrl.pc_sel;
  assign im_select  = ctrl.im_select;
  assign branch     = ctrl.branch;
  assign halted     = ctrl.halted;
  assign carry_flag = carry_flag_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-cycle output vectors for each instruction
// class, carry latching, asynchronous reset, back-to-back flow and HALT/run.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] opcode;
  logic       carry;
  logic       run;
  logic [3:0] alu_op;
  logic       sel1, sel3, sel5, sel6, re, wr, reg_wrt, pc_sel, im_select, branch;
  logic       carry_flag, halted;
  logic [1:0] sel2;
  logic [16:0] obs;

  int total = 0;
  int bad   = 0;

  // Observed vector: {alu_op, sel1, sel2, sel3, sel5, sel6, re, wr, reg_wrt, pc_sel, im_select, branch, halted}
  localparam logic [16:0] Z     = 17'h00000;
  localparam logic [16:0] M_S1  = 17'h01000;
  localparam logic [16:0] M_S2  = 17'h00400;
  localparam logic [16:0] M_S3  = 17'h00200;
  localparam logic [16:0] M_S6  = 17'h00080;
  localparam logic [16:0] M_RE  = 17'h00040;
  localparam logic [16:0] M_WR  = 17'h00020;
  localparam logic [16:0] M_RW  = 17'h00010;
  localparam logic [16:0] M_PC  = 17'h00008;
  localparam logic [16:0] M_IM  = 17'h00004;
  localparam logic [16:0] M_BR  = 17'h00002;
  localparam logic [16:0] M_H   = 17'h00001;
  localparam logic [16:0] A_SUB = 17'h02000;

  control_unit #(.MEM_WAIT(1), .HALT_OP(4'hF)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .carry      (carry),
    .run        (run),
    .alu_op     (alu_op),
    .sel1       (sel1),
    .sel2       (sel2),
    .sel3       (sel3),
    .sel5       (sel5),
    .sel6       (sel6),
    .re         (re),
    .wr         (wr),
    .reg_wrt    (reg_wrt),
    .pc_sel     (pc_sel),
    .im_select  (im_select),
    .branch     (branch),
    .carry_flag (carry_flag),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  assign obs = {alu_op, sel1, sel2, sel3, sel5, sel6, re, wr, reg_wrt, pc_sel, im_select, branch, halted};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; opcode = 4'h0; carry = 1'b0; run = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (obs !== M_IM) begin bad++; $display("FAIL reset_outputs got=%05h exp=%05h", obs, M_IM); end
    total++;
    if (carry_flag !== 1'b0) begin bad++; $display("FAIL reset_carry got=%0b exp=0", carry_flag); end
    reset = 1'b1;
    $display("reset: outputs=%05h carry_flag=%0b", obs, carry_flag);
  endtask

  task automatic test_add();
    logic [16:0] exp [5];
    exp = '{M_IM, Z, M_S1, M_S1 | M_RW | M_PC, M_IM};
    opcode = 4'h0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      total++;
      if (obs !== exp[i]) begin bad++; $display("FAIL add cyc=%0d got=%05h exp=%05h", i, obs, exp[i]); end
    end
    $display("add: 4-cycle sequence checked");
  endtask

  task automatic test_rtype();
    logic [16:0] exp [5];
    for (int op = 1; op <= 6; op++) begin
      opcode = 4'(op);
      exp = '{M_IM, Z, M_S1 | {4'(op), 13'h0}, M_S1 | M_RW | M_PC | {4'(op), 13'h0}, M_IM};
      for (int i = 0; i < 5; i++) begin
        if (i > 0) step();
        total++;
        if (obs !== exp[i]) begin bad++; $display("FAIL rtype op=%0h cyc=%0d got=%05h exp=%05h", op, i, obs, exp[i]); end
      end
      $display("rtype op=%0h: sequence checked", op);
    end
  endtask

  task automatic test_addi();
    logic [16:0] exp [5];
    exp = '{M_IM, Z, M_S2, M_S2 | M_S1 | M_RW | M_PC, M_IM};
    opcode = 4'h7;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      total++;
      if (obs !== exp[i]) begin bad++; $display("FAIL addi cyc=%0d got=%05h exp=%05h", i, obs, exp[i]); end
    end
    $display("addi: 4-cycle sequence checked");
  endtask

  task automatic test_lw();
    logic [16:0] exp [7];
    exp = '{M_IM, Z, M_S2, M_S2 | M_RE, M_S2 | M_RE, M_S2 | M_S3 | M_RW | M_PC, M_IM};
    opcode = 4'h8;
    for (int i = 0; i < 7; i++) begin
      if (i > 0) step();
      total++;
      if (obs !== exp[i]) begin bad++; $display("FAIL lw cyc=%0d got=%05h exp=%05h", i, obs, exp[i]); end
    end
    $display("lw: 6-cycle sequence checked");
  endtask

  task automatic test_sw();
    logic [16:0] exp [6];
    exp = '{M_IM, Z, M_S2, M_S2 | M_WR, M_S2 | M_WR | M_PC, M_IM};
    opcode = 4'h9;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      total++;
      if (obs !== exp[i]) begin bad++; $display("FAIL sw cyc=%0d got=%05h exp=%05h", i, obs, exp[i]); end
    end
    $display("sw: 5-cycle sequence checked");
  endtask

  task automatic test_branch_jump();
    logic [16:0] exp_beq [4];
    logic [16:0] exp_jmp [4];
    exp_beq = '{M_IM, Z, A_SUB | M_BR | M_PC, M_IM};
    exp_jmp = '{M_IM, Z, M_S6 | M_PC, M_IM};
    opcode = 4'hA;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      total++;
      if (obs !== exp_beq[i]) begin bad++; $display("FAIL beq cyc=%0d got=%05h exp=%05h", i, obs, exp_beq[i]); end
    end
    $display("beq: 3-cycle sequence checked");
    opcode = 4'hB;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      total++;
      if (obs !== exp_jmp[i]) begin bad++; $display("FAIL jmp cyc=%0d got=%05h exp=%05h", i, obs, exp_jmp[i]); end
    end
    $display("jmp: 3-cycle sequence checked");
  endtask

  task automatic test_nop();
    logic [16:0] exp [3];
    exp = '{M_IM, M_PC, M_IM};
    for (int op = 12; op <= 14; op++) begin
      opcode = 4'(op);
      for (int i = 0; i < 3; i++) begin
        if (i > 0) step();
        total++;
        if (obs !== exp[i]) begin bad++; $display("FAIL nop op=%0h cyc=%0d got=%05h exp=%05h", op, i, obs, exp[i]); end
      end
      $display("nop op=%0h: 2-cycle sequence checked", op);
    end
  endtask

  task automatic test_carry();
    // ADD with carry=1 sets the flag; BEQ leaves it; SUB with carry=0 clears it; ADDI sets it again.
    opcode = 4'h0; carry = 1'b1;
    step(); step(); step();
    total++;
    if (carry_flag !== 1'b1) begin bad++; $display("FAIL carry_add got=%0b exp=1", carry_flag); end
    step();
    opcode = 4'hA; carry = 1'b0;
    step(); step(); step();
    total++;
    if (carry_flag !== 1'b1) begin bad++; $display("FAIL carry_beq_hold got=%0b exp=1", carry_flag); end
    opcode = 4'h1;
    step(); step(); step();
    total++;
    if (carry_flag !== 1'b0) begin bad++; $display("FAIL carry_sub got=%0b exp=0", carry_flag); end
    step();
    opcode = 4'h7; carry = 1'b1;
    step(); step(); step(); step();
    total++;
    if (carry_flag !== 1'b1) begin bad++; $display("FAIL carry_addi got=%0b exp=1", carry_flag); end
    carry = 1'b0;
    $display("carry: flag=%0b after addi", carry_flag);
  endtask

  task automatic test_mid_reset();
    logic [16:0] exp [4];
    exp = '{Z, M_S1, M_S1 | M_RW | M_PC, M_IM};
    opcode = 4'h0;
    step(); step();
    total++;
    if (obs !== M_S1) begin bad++; $display("FAIL midrst_exec got=%05h exp=%05h", obs, M_S1); end
    #2 reset = 1'b0;
    #1;
    total++;
    if (obs !== M_IM) begin bad++; $display("FAIL midrst_async got=%05h exp=%05h", obs, M_IM); end
    total++;
    if (carry_flag !== 1'b0) begin bad++; $display("FAIL midrst_carry got=%0b exp=0", carry_flag); end
    step();
    total++;
    if (obs !== M_IM) begin bad++; $display("FAIL midrst_held got=%05h exp=%05h", obs, M_IM); end
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (obs !== exp[i]) begin bad++; $display("FAIL midrst_resume cyc=%0d got=%05h exp=%05h", i, obs, exp[i]); end
    end
    $display("mid_reset: restart from FETCH checked");
  endtask

  task automatic test_back_to_back();
    logic [16:0] exp [10];
    logic [3:0]  ops [10];
    int          pcs;
    exp = '{M_IM, M_PC, M_IM, Z, M_S6 | M_PC, M_IM, Z, M_S2, M_S2 | M_S1 | M_RW | M_PC, M_IM};
    ops = '{4'hC, 4'hC, 4'hB, 4'hB, 4'hB, 4'h7, 4'h7, 4'h7, 4'h7, 4'h7};
    pcs = 0;
    run = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) step();
      total++;
      if (obs !== exp[i]) begin bad++; $display("FAIL b2b cyc=%0d got=%05h exp=%05h", i, obs, exp[i]); end
      if (pc_sel === 1'b1) pcs++;
      opcode = ops[i];
    end
    total++;
    if (pcs != 3) begin bad++; $display("FAIL b2b_pc_count got=%0d exp=3", pcs); end
    run = 1'b0;
    $display("back_to_back: nop/jmp/addi with %0d pc_sel pulses", pcs);
  endtask

  task automatic test_halt();
    opcode = 4'hF; run = 1'b0;
    step();
    total++;
    if (obs !== Z) begin bad++; $display("FAIL halt_decode got=%05h exp=%05h", obs, Z); end
    for (int i = 0; i < 10; i++) begin
      step();
      total++;
      if (obs !== M_H) begin bad++; $display("FAIL halt_hold cyc=%0d got=%05h exp=%05h", i, obs, M_H); end
    end
    opcode = 4'h0;
    run = 1'b1;
    step();
    total++;
    if (obs !== M_IM) begin bad++; $display("FAIL halt_run got=%05h exp=%05h", obs, M_IM); end
    run = 1'b0;
    step();
    total++;
    if (obs !== Z) begin bad++; $display("FAIL halt_refetch got=%05h exp=%05h", obs, Z); end
    $display("halt: held 10 cycles, resumed on run");
  endtask

  initial begin
    test_reset();
    test_add();
    test_rtype();
    test_addi();
    test_lw();
    test_sw();
    test_branch_jump();
    test_nop();
    test_carry();
    test_mid_reset();
    test_back_to_back();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
